// File: rtl/taillights_pkg.sv
// Shared types for the taillight datapath.
//   cmd_t      : prioritized command handed from the input conditioner to the FSM
//   encode_cmd : maps debounced switch levels onto a cmd_t
package taillights_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE        = 3'd0,
        CMD_LEFT        = 3'd1,
        CMD_RIGHT       = 3'd2,
        CMD_HAZ         = 3'd3,
        CMD_BRAKE       = 3'd4,
        CMD_BRAKE_LEFT  = 3'd5,
        CMD_BRAKE_RIGHT = 3'd6
    } cmd_t;

    // Hazard (explicit, or both turn switches together) outranks brake.
    // Once that case is excluded, left and right are never both set below.
    function automatic cmd_t encode_cmd(input logic left,
                                        input logic right,
                                        input logic haz,
                                        input logic brake);
        cmd_t cmd;
        if (haz || (left && right)) cmd = CMD_HAZ;
        else if (brake && left)     cmd = CMD_BRAKE_LEFT;
        else if (brake && right)    cmd = CMD_BRAKE_RIGHT;
        else if (brake)             cmd = CMD_BRAKE;
        else if (left)              cmd = CMD_LEFT;
        else if (right)             cmd = CMD_RIGHT;
        else                        cmd = CMD_IDLE;
        return cmd;
    endfunction

endpackage

// File: rtl/taillights_debounce.sv
// Two-flop synchronizer followed by a counter-based debouncer for one switch.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   sw_i    : raw switch, asynchronous to clk
//   level_o : debounced level; follows sw_i only after it has differed from
//             the current level for DEBOUNCE_CYCLES consecutive synced cycles
module taillights_debounce
    import taillights_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic level_o
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synced input disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; without them
        // the unassigned branches would infer latches.
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: non-blocking assignments in clocked logic so every flop samples the
    // pre-edge value of its source; blocking here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/taillights_input_conditioner.sv
// Front end of the taillight datapath, directly upstream of the taillight FSM.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   left_sw_i    : raw left-turn switch (async)
//   right_sw_i   : raw right-turn switch (async)
//   haz_sw_i     : raw hazard switch (async)
//   brake_sw_i   : raw brake switch (async)
//   left_o       : debounced left level
//   right_o      : debounced right level
//   haz_o        : debounced hazard level
//   brake_o      : debounced brake level
//   cmd_o        : registered prioritized command
//   cmd_change_o : one-cycle pulse in the first cycle cmd_o shows a new value
//   tick_o       : one-cycle sequencing pulse every TICK_CYCLES cycles,
//                  restarted by each command change
module taillights_input_conditioner
    import taillights_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned TICK_CYCLES     = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic left_sw_i,
    input  logic right_sw_i,
    input  logic haz_sw_i,
    input  logic brake_sw_i,
    output logic left_o,
    output logic right_o,
    output logic haz_o,
    output logic brake_o,
    output cmd_t cmd_o,
    output logic cmd_change_o,
    output logic tick_o
);

    localparam int unsigned   TW       = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

    // ---------------------------------------------------------------
    // Per-switch synchronize + debounce
    // ---------------------------------------------------------------
    taillights_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (left_sw_i),
        .level_o (left_o)
    );

    taillights_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (right_sw_i),
        .level_o (right_o)
    );

    taillights_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_haz (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (haz_sw_i),
        .level_o (haz_o)
    );

    taillights_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_brake (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (brake_sw_i),
        .level_o (brake_o)
    );

    // ---------------------------------------------------------------
    // Command encode and register
    // ---------------------------------------------------------------
    cmd_t cmd_q;
    cmd_t cmd_d;
    logic cmd_change_q;
    logic cmd_change_d;

    // The change flag is registered alongside the command so both appear in
    // the same cycle; resetting cmd_q to CMD_IDLE matches the all-zero
    // debounced levels, so nothing pulses on reset release.
    assign cmd_d        = encode_cmd(left_o, right_o, haz_o, brake_o);
    assign cmd_change_d = (cmd_d != cmd_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= CMD_IDLE;
            cmd_change_q <= 1'b0;
        end else begin
            cmd_q        <= cmd_d;
            cmd_change_q <= cmd_change_d;
        end
    end

    assign cmd_o        = cmd_q;
    assign cmd_change_o = cmd_change_q;

    // ---------------------------------------------------------------
    // Sequencing tick
    // ---------------------------------------------------------------
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;

    // A command change restarts the period from zero so the FSM gets a full
    // period on its new pattern; the restart outranks a coincident wrap.
    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (cmd_change_q || (tick_cnt_q == TICK_MAX)) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_o = (tick_cnt_q == TICK_MAX) && !cmd_change_q;

endmodule
